// File: rtl/moving_avg_pkg.sv
// Shared types and helpers for the multi-channel moving-average filter.
// Per-channel state uses fixed maximum widths (LOG2_MAX_DEPTH <= 15, DATA_W + LOG2_MAX_DEPTH <= 32).
package moving_avg_pkg;

  localparam int MAX_PTR_W = 16;
  localparam int MAX_ACC_W = 32;

  typedef struct packed {
    logic [MAX_PTR_W-1:0] wptr;
    logic [MAX_PTR_W-1:0] fill;
    logic [MAX_ACC_W-1:0] acc;
  } chan_state_t;

  function automatic int acc_w(input int data_w, input int log2_max_depth);
    return data_w + log2_max_depth;
  endfunction

  function automatic int clamp_win(input int k, input int max_k);
    return (k > max_k) ? max_k : k;
  endfunction

endpackage

// File: rtl/mavg_hist_ram.sv
// Sample history storage for all channels, addressed {chan, ptr}.
// One synchronous write port, one combinational read port.
module mavg_hist_ram #(
  parameter int DATA_W = 12,
  parameter int CH_W   = 2,
  parameter int PTR_W  = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_chan,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [CH_W-1:0]   rd_chan,
  input  logic [PTR_W-1:0]  rd_ptr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [1 << (CH_W + PTR_W)];

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_chan, wr_ptr}] <= wr_data;
  end

  assign rd_data = mem[{rd_chan, rd_ptr}];

endmodule

// File: rtl/moving_avg_filter.sv
// Multi-channel boxcar filter: running sum per channel, mean over 2**k samples by shift.
// Define MOVING_AVG_ROUND_EN for round-half-up output instead of truncation.
module moving_avg_filter
  import moving_avg_pkg::*;
#(
  parameter int DATA_W         = 12,
  parameter int CHANNELS       = 4,
  parameter int LOG2_MAX_DEPTH = 4,
  parameter int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int WL_W           = $clog2(LOG2_MAX_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_chan,
  input  logic [DATA_W-1:0] in_data,
  input  logic [WL_W-1:0]   win_log2,
  input  logic              clear,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_chan,
  output logic [DATA_W-1:0] out_data,
  output logic              out_primed
);

  localparam int DEPTH = 1 << LOG2_MAX_DEPTH;
  localparam int PTR_W = LOG2_MAX_DEPTH;
  localparam int ACC_W = acc_w(DATA_W, LOG2_MAX_DEPTH);
  localparam logic [MAX_PTR_W-1:0] PTR_MASK = MAX_PTR_W'(DEPTH - 1);
  localparam logic [MAX_PTR_W-1:0] FILL_MAX = MAX_PTR_W'(DEPTH);

  chan_state_t state [CHANNELS];
  chan_state_t cur, nxt;
  logic [WL_W-1:0] k_reg, k_eff;
  logic flush, accept, chan_ok, primed_new;
  logic [CH_W-1:0] chan_idx;
  logic [MAX_PTR_W-1:0] win;
  logic [PTR_W-1:0] win_lo, wptr_lo, rd_ptr;
  logic [DATA_W-1:0] rd_data, old;

  // Divide by 2**k with optional round-half-up; clips to the full-scale sample.
  function automatic logic [DATA_W-1:0] scale(input logic [ACC_W-1:0] acc,
                                               input logic [WL_W-1:0] k);
    logic [ACC_W:0] sum;
    logic [ACC_W:0] q;
    sum = {1'b0, acc};
`ifdef MOVING_AVG_ROUND_EN
    if (k != '0) sum = sum + ((ACC_W+1)'(1) << (k - 1'b1));
`endif
    q = sum >> k;
    if (q > (ACC_W+1)'({DATA_W{1'b1}})) return '1;
    return q[DATA_W-1:0];
  endfunction

  always_comb begin
    k_eff    = WL_W'(clamp_win(int'(win_log2), LOG2_MAX_DEPTH));
    flush    = clear || (k_eff != k_reg);
    chan_ok  = int'(in_chan) < CHANNELS;
    accept   = in_valid && !flush && chan_ok;
    chan_idx = chan_ok ? in_chan : '0;
    cur      = state[chan_idx];
    win      = MAX_PTR_W'(1) << k_eff;
    win_lo   = PTR_W'(1) << k_eff;
    wptr_lo  = cur.wptr[PTR_W-1:0];
    // Full-depth window wraps win_lo to 0, reading the slot about to be overwritten.
    rd_ptr   = wptr_lo - win_lo;
    old      = (cur.fill >= win) ? rd_data : '0;
    nxt.wptr = (cur.wptr + MAX_PTR_W'(1)) & PTR_MASK;
    nxt.fill = (cur.fill >= FILL_MAX) ? FILL_MAX : cur.fill + MAX_PTR_W'(1);
    nxt.acc  = cur.acc + MAX_ACC_W'(in_data) - MAX_ACC_W'(old);
    primed_new = nxt.fill >= win;
  end

  mavg_hist_ram #(
    .DATA_W (DATA_W),
    .CH_W   (CH_W),
    .PTR_W  (PTR_W)
  ) u_hist (
    .clk     (clk),
    .wr_en   (accept),
    .wr_chan (chan_idx),
    .wr_ptr  (wptr_lo),
    .wr_data (in_data),
    .rd_chan (chan_idx),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_data)
  );

  // State update: read-modify-write completes in one cycle, so back-to-back samples see fresh state
  always_ff @(posedge clk) begin
    if (reset) k_reg <= '0;
    else       k_reg <= k_eff;
    for (int c = 0; c < CHANNELS; c++) begin
      if (reset || flush)                      state[c] <= '0;
      else if (accept && chan_idx == CH_W'(c)) state[c] <= nxt;
    end
  end

  // Output register: one-cycle latency
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_chan   <= '0;
      out_data   <= '0;
      out_primed <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        out_chan   <= chan_idx;
        out_data   <= scale(ACC_W'(nxt.acc), k_eff);
        out_primed <= primed_new;
      end
    end
  end

endmodule

// File: tb/tb_moving_avg_filter.sv
// Scoreboard bench for moving_avg_filter: stimulus pushes expected results, a monitor pops and compares.
// Build with +define+MOVING_AVG_ROUND_EN to check the rounding variant.
module tb_moving_avg_filter;

  localparam int DATA_W = 12;
  localparam int CH_W   = 2;
  localparam int WL_W   = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [CH_W-1:0]   in_chan;
  logic [DATA_W-1:0] in_data;
  logic [WL_W-1:0]   win_log2;
  logic              clear;
  logic              out_valid;
  logic [CH_W-1:0]   out_chan;
  logic [DATA_W-1:0] out_data;
  logic              out_primed;

  typedef struct {
    int ch;
    int data;
    bit primed;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_idle = 1'b0;
  bit   chk_end  = 1'b0;

  moving_avg_filter dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_chan    (in_chan),
    .in_data    (in_data),
    .win_log2   (win_log2),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_chan   (out_chan),
    .out_data   (out_data),
    .out_primed (out_primed)
  );

  always #5 clk = ~clk;

  // Expected mean of a window sum for window 2**k, including the optional rounding.
  function automatic int avg(input int sum, input int k);
    int s;
    s = sum;
`ifdef MOVING_AVG_ROUND_EN
    if (k > 0) s = s + (1 << (k - 1));
`endif
    s = s >> k;
    if (s > 4095) s = 4095;
    return s;
  endfunction

  always @(negedge clk) begin
    if (chk_idle) begin
      n_vec++;
      if (out_valid !== 1'b0 || out_chan !== '0 || out_data !== '0 || out_primed !== 1'b0) begin
        n_err++;
        $display("FAIL reset_state: got valid=%0b chan=%0d data=%0d primed=%0b, required all 0",
                 out_valid, out_chan, out_data, out_primed);
      end
    end
    if (out_valid === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: got chan=%0d data=%0d, required no output", out_chan, out_data);
      end else begin
        e = sb.pop_front();
        if (int'(out_chan) != e.ch || int'(out_data) != e.data || out_primed !== e.primed) begin
          n_err++;
          $display("FAIL result: got chan=%0d data=%0d primed=%0b, required chan=%0d data=%0d primed=%0b",
                   out_chan, out_data, out_primed, e.ch, e.data, e.primed);
        end
      end
    end
    if (chk_end) begin
      n_vec++;
      if (sb.size() != 0) begin
        n_err++;
        $display("FAIL missing_out: got %0d results outstanding, required 0", sb.size());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input int d, input int exp_data, input bit exp_primed);
    exp_t x;
    x.ch = ch; x.data = exp_data; x.primed = exp_primed;
    in_valid = 1'b1; in_chan = CH_W'(ch); in_data = DATA_W'(d);
    sb.push_back(x);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drop(input int ch, input int d);
    in_valid = 1'b1; in_chan = CH_W'(ch); in_data = DATA_W'(d);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_idle_check();
    chk_idle = 1'b1;
    @(negedge clk); #1;
    chk_idle = 1'b0;
  endtask

  int t1 [5] = '{1, 3, 6, 10, 14};

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_chan = '0; in_data = '0; win_log2 = '0; clear = 1'b0;
    idle(2);
    pulse_idle_check();
    reset = 1'b0; win_log2 = 3'd2;
    idle(2);

    // Scenario 1: k=2, back-to-back on channel 0
    for (int i = 0; i < 5; i++) send(0, 4 * (i + 1), t1[i], i >= 3);

    // Clear with a sample present: sample dropped
    clear = 1'b1;
    drop(0, 99);
    clear = 1'b0;

    // Scenario 2: interleave channel 1 between channel 0 samples
    for (int i = 0; i < 5; i++) begin
      send(0, 4 * (i + 1), t1[i], i >= 3);
      send(1, 100, 25 * ((i < 3) ? i + 1 : 4), i >= 3);
    end

    // Scenario 3: full-scale on channel 3 at k=4, then drain with zeros
    win_log2 = 3'd4;
    idle(1);
    for (int n = 1; n <= 20; n++) send(3, 4095, avg(((n < 16) ? n : 16) * 4095, 4), n >= 16);
    for (int m = 1; m <= 16; m++) send(3, 0, avg((16 - m) * 4095, 4), 1'b1);

    // Scenario 4: window change mid-stream acts as clear and drops that sample
    win_log2 = 3'd2;
    idle(1);
    send(0, 4, 1, 1'b0);
    win_log2 = 3'd3;
    drop(0, 50);
    send(0, 8, 1, 1'b0);

    // Scenario 5: reset mid-stream, then oversized win_log2 clamps to 4
    win_log2 = 3'd2;
    idle(1);
    send(2, 10, avg(10, 2), 1'b0);
    send(2, 20, avg(30, 2), 1'b0);
    send(2, 30, avg(60, 2), 1'b0);
    reset = 1'b1;
    idle(1);
    pulse_idle_check();
    reset = 1'b0;
    idle(2);
    send(2, 40, 10, 1'b0);
    send(2, 40, 20, 1'b0);
    win_log2 = 3'd7;
    idle(1);
    for (int n = 1; n <= 16; n++) send(1, 32, avg(32 * n, 4), n == 16);

    // Scenario 6: rounding behaviour
    win_log2 = 3'd2;
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
`ifdef MOVING_AVG_ROUND_EN
    send(0, 6, 2, 1'b0);
`else
    send(0, 6, 1, 1'b0);
`endif

    idle(2);
    chk_end = 1'b1;
    @(negedge clk); #1;
    chk_end = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1);
  end

endmodule
